// File: rtl/ordered_set_generator.sv
// ordered_set_generator: turns ordered-set requests, user bytes and LFSR idles into a K/D symbol stream
package aurora_pkg;
   typedef enum logic [1:0] {NONE = 2'd0, SP = 2'd1, I = 2'd2, VER = 2'd3} ordered_sets_e;
endpackage

module ordered_set_generator
   import aurora_pkg::*;
(
   input  logic          clk,
   input  logic          rst_n,
   input  ordered_sets_e ordered_sets,
   input  logic          init_finished,
   input  logic [7:0]    tx_data,
   input  logic          tx_valid,
   output logic          tx_ready,
   output logic [7:0]    tx_symbol,
   output logic          tx_is_k,
   output logic          seq_start
);
   logic [1:0] pos, pos_nxt;
   logic       ver, ver_nxt;
   logic [6:0] lfsr;
   logic [4:0] a_gap, a_gap_nxt;
   logic [7:0] sym_nxt, idle_sym;
   logic       k_nxt, ss_nxt, idle_a, a_emit;
   assign tx_ready = init_finished && (ordered_sets == NONE) && (pos == 2'd0);
   assign idle_a   = (lfsr[2:0] == 3'b000) && (a_gap >= 5'd16);
   assign idle_sym = idle_a ? 8'h7C : lfsr[0] ? 8'hBC : 8'h1C;
   always_comb begin
      pos_nxt = pos;
      ver_nxt = ver;
      sym_nxt = idle_sym;
      k_nxt   = 1'b1;
      ss_nxt  = 1'b0;
      a_emit  = 1'b0;
      if (pos != 2'd0) begin
         sym_nxt = ver ? 8'hB5 : 8'h95;
         k_nxt   = 1'b0;
         pos_nxt = pos + 2'd1;
      end else if (ordered_sets == SP || ordered_sets == VER) begin
         sym_nxt = 8'hBC;
         ss_nxt  = 1'b1;
         pos_nxt = 2'd1;
         ver_nxt = (ordered_sets == VER);
      end else if (tx_valid && tx_ready) begin
         sym_nxt = tx_data;
         k_nxt   = 1'b0;
      end else begin
         a_emit  = idle_a;
      end
      a_gap_nxt = a_emit ? 5'd0 : (a_gap >= 5'd16) ? 5'd16 : a_gap + 5'd1;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pos       <= 2'd0;
         ver       <= 1'b0;
         lfsr      <= 7'h7F;
         a_gap     <= 5'd0;
         tx_symbol <= 8'hBC;
         tx_is_k   <= 1'b1;
         seq_start <= 1'b0;
      end else begin
         pos       <= pos_nxt;
         ver       <= ver_nxt;
         lfsr      <= {lfsr[5:0], lfsr[6] ^ lfsr[5]};
         a_gap     <= a_gap_nxt;
         tx_symbol <= sym_nxt;
         tx_is_k   <= k_nxt;
         seq_start <= ss_nxt;
      end
   end
endmodule

// File: tb/tb_ordered_set_generator.sv
// tb_ordered_set_generator: directed checks of sequences, idles, data path and reset abort
module tb_ordered_set_generator;
   import aurora_pkg::*;
   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   ordered_sets_e ordered_sets = SP;
   logic          init_finished = 1'b0;
   logic [7:0]    tx_data = 8'h00;
   logic          tx_valid = 1'b0;
   logic          tx_ready;
   logic [7:0]    tx_symbol;
   logic          tx_is_k;
   logic          seq_start;
   int            checks = 0;
   int            failures = 0;
   int            cyc = 0;
   logic [6:0]    m_lfsr = 7'h7F;
   logic [4:0]    m_gap = 5'd0;

   ordered_set_generator dut (
      .clk(clk), .rst_n(rst_n), .ordered_sets(ordered_sets), .init_finished(init_finished),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .tx_symbol(tx_symbol), .tx_is_k(tx_is_k), .seq_start(seq_start)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // idle=1: expected symbol comes from the reference idle LFSR; else e = {k, symbol}
   task automatic step(input string tag, input bit idle, input logic [8:0] e, input logic ss);
      logic [8:0] x;
      logic       a;
      @(posedge clk);
      a = idle && (m_lfsr[2:0] == 3'b000) && (m_gap >= 5'd16);
      x = idle ? {1'b1, a ? 8'h7C : m_lfsr[0] ? 8'hBC : 8'h1C} : e;
      m_gap  = a ? 5'd0 : (m_gap >= 5'd16) ? 5'd16 : m_gap + 5'd1;
      m_lfsr = {m_lfsr[5:0], m_lfsr[6] ^ m_lfsr[5]};
      cyc++;
      #1;
      check(tag, {23'd0, tx_is_k, tx_symbol}, {23'd0, x});
      check({tag, "_ss"}, {31'd0, seq_start}, {31'd0, ss});
   endtask

   initial begin
      int last_a;
      int sent;
      int n;
      repeat (2) @(posedge clk);
      #1;
      check("rst_sym", {23'd0, tx_is_k, tx_symbol}, {23'd0, 9'h1BC});
      check("rst_ss", {31'd0, seq_start}, 32'd0);
      check("rst_ready", {31'd0, tx_ready}, 32'd0);
      rst_n = 1'b1;
      for (int r = 0; r < 2; r++) begin
         step("sp_k", 0, 9'h1BC, 1);
         step("sp_d1", 0, 9'h095, 0);
         step("sp_d2", 0, 9'h095, 0);
         step("sp_d3", 0, 9'h095, 0);
      end
      step("sw_k", 0, 9'h1BC, 1);
      step("sw_d1", 0, 9'h095, 0);
      ordered_sets = VER;
      step("sw_d2", 0, 9'h095, 0);
      step("sw_d3", 0, 9'h095, 0);
      step("ver_k", 0, 9'h1BC, 1);
      step("ver_d1", 0, 9'h0B5, 0);
      step("ver_d2", 0, 9'h0B5, 0);
      step("ver_d3", 0, 9'h0B5, 0);
      ordered_sets = I;
      init_finished = 1'b1;
      #1;
      check("i_ready", {31'd0, tx_ready}, 32'd0);
      last_a = -1;
      for (int c = 0; c < 1000; c++) begin
         step("idle", 1, 9'h000, 0);
         if (tx_symbol == 8'h7C) begin
            if (last_a >= 0) check("a_spacing", {31'd0, (cyc - last_a) >= 16}, 32'd1);
            last_a = cyc;
         end
      end
      check("a_seen", {31'd0, last_a >= 0}, 32'd1);
      ordered_sets = NONE;
      sent = 0;
      n = 0;
      while (sent < 256 && n < 3000) begin
         tx_valid = ($urandom_range(3) != 0);
         tx_data  = sent[7:0];
         #1;
         check("d_ready", {31'd0, tx_ready}, 32'd1);
         step("data", !tx_valid, {1'b0, sent[7:0]}, 0);
         if (tx_valid) sent++;
         n++;
      end
      check("data_count", sent, 256);
      tx_valid = 1'b1;
      tx_data  = 8'hA5;
      ordered_sets = VER;
      #1;
      check("ov_ready0", {31'd0, tx_ready}, 32'd0);
      step("ov_k", 0, 9'h1BC, 1);
      ordered_sets = NONE;
      #1;
      check("ov_ready1", {31'd0, tx_ready}, 32'd0);
      step("ov_d1", 0, 9'h0B5, 0);
      check("ov_ready2", {31'd0, tx_ready}, 32'd0);
      step("ov_d2", 0, 9'h0B5, 0);
      check("ov_ready3", {31'd0, tx_ready}, 32'd0);
      step("ov_d3", 0, 9'h0B5, 0);
      check("ov_ready4", {31'd0, tx_ready}, 32'd1);
      step("ov_byte", 0, 9'h0A5, 0);
      tx_valid = 1'b0;
      ordered_sets = SP;
      step("rm_k", 0, 9'h1BC, 1);
      step("rm_d1", 0, 9'h095, 0);
      rst_n = 1'b0;
      m_lfsr = 7'h7F;
      m_gap = 5'd0;
      #1;
      check("rm_sym", {23'd0, tx_is_k, tx_symbol}, {23'd0, 9'h1BC});
      check("rm_ss", {31'd0, seq_start}, 32'd0);
      @(posedge clk);
      #2;
      check("rm_hold", {23'd0, tx_is_k, tx_symbol}, {23'd0, 9'h1BC});
      rst_n = 1'b1;
      step("rm_fresh_k", 0, 9'h1BC, 1);
      step("rm_fresh_d1", 0, 9'h095, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
